// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the VGA adapter pixel-write port between queued CPU
// plots and a full-screen clear engine; at most one pixel per cycle.
// Optional clear engine is built only when FLOW_CLEAR_ENGINE_EN is defined.
module vga_plot_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIDTH      = 160,
    parameter int unsigned HEIGHT     = 120
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          cpu_plot,
    input  logic [7:0]                    cpu_x,
    input  logic [6:0]                    cpu_y,
    input  logic [14:0]                   cpu_color,
    output logic                          cpu_ready,
    input  logic                          clear_start,
    input  logic [14:0]                   clear_color,
    output logic                          clear_busy,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          range_error,
    output logic [7:0]                    vga_x,
    output logic [6:0]                    vga_y,
    output logic [14:0]                   vga_color,
    output logic                          vga_plot
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = 30;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic          in_range;
    logic          accept;
    logic          push;
    logic          pop;

    assign pending   = count;
    assign cpu_ready = (count != PW'(FIFO_DEPTH));
    assign in_range  = (32'(cpu_x) < WIDTH) && (32'(cpu_y) < HEIGHT);
    assign accept    = cpu_plot && cpu_ready;
    assign push      = accept && in_range;

`ifdef FLOW_CLEAR_ENGINE_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t        state;
    logic [7:0]    cx;
    logic [6:0]    cy;
    logic [14:0]   fill_color;

    assign clear_busy = (state == S_CLEAR);
    // A starting clear takes the port ahead of any queued pixel.
    assign pop = (state == S_IDLE) && !clear_start && (count != '0);
`else
    logic unused_clear;

    assign unused_clear = ^{clear_start, clear_color};
    assign clear_busy   = 1'b0;
    assign pop          = (count != '0);
`endif

    // FIFO storage; contents need no reset since the pointers are flushed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {cpu_x, cpu_y, cpu_color};
        end
    end

    // FIFO pointers, occupancy and sticky out-of-range flag.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            range_error <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
            if (accept && !in_range) range_error <= 1'b1;
        end
    end

    // Port arbitration FSM, clear sweep and registered adapter outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_color  <= '0;
            vga_plot   <= 1'b0;
`ifdef FLOW_CLEAR_ENGINE_EN
            state      <= S_IDLE;
            cx         <= '0;
            cy         <= '0;
            fill_color <= '0;
`endif
        end else begin
`ifdef FLOW_CLEAR_ENGINE_EN
            case (state)
                S_IDLE: begin
                    if (clear_start) begin
                        state      <= S_CLEAR;
                        cx         <= '0;
                        cy         <= '0;
                        fill_color <= clear_color;
                        vga_plot   <= 1'b0;
                    end else if (pop) begin
                        {vga_x, vga_y, vga_color} <= mem[rd_ptr];
                        vga_plot <= 1'b1;
                    end else begin
                        vga_plot <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    vga_x     <= cx;
                    vga_y     <= cy;
                    vga_color <= fill_color;
                    vga_plot  <= 1'b1;
                    if (cx == 8'(WIDTH - 1)) begin
                        cx <= '0;
                        if (cy == 7'(HEIGHT - 1)) begin
                            state <= S_IDLE;
                        end else begin
                            cy <= cy + 7'(1);
                        end
                    end else begin
                        cx <= cx + 8'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
`else
            if (pop) begin
                {vga_x, vga_y, vga_color} <= mem[rd_ptr];
                vga_plot <= 1'b1;
            end else begin
                vga_plot <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: random and directed stimulus against a queue-based
// reference model of the plot arbiter (FIFO path, plus clear sweep when built).
module tb_vga_plot_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 160;
    localparam int unsigned H     = 120;
    localparam int unsigned NPIX  = W * H;
`ifdef FLOW_CLEAR_ENGINE_EN
    localparam bit ENG = 1'b1;
`else
    localparam bit ENG = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        cpu_plot;
    logic [7:0]  cpu_x;
    logic [6:0]  cpu_y;
    logic [14:0] cpu_color;
    logic        cpu_ready;
    logic        clear_start;
    logic [14:0] clear_color;
    logic        clear_busy;
    logic [$clog2(DEPTH):0] pending;
    logic        range_error;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [14:0] vga_color;
    logic        vga_plot;

    vga_plot_arbiter #(.FIFO_DEPTH(DEPTH), .WIDTH(W), .HEIGHT(H)) dut (
        .clock(clock), .resetn(resetn),
        .cpu_plot(cpu_plot), .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_color(cpu_color),
        .cpu_ready(cpu_ready), .clear_start(clear_start), .clear_color(clear_color),
        .clear_busy(clear_busy), .pending(pending), .range_error(range_error),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queue of pending pixels plus remaining sweep pixel count.
    logic [29:0] mq[$];
    logic [29:0] rq[$];
    int unsigned sweep_left = 0;
    logic [14:0] m_fill = '0;
    logic        m_plot = 1'b0;
    logic [7:0]  m_x = '0;
    logic [6:0]  m_y = '0;
    logic [14:0] m_c = '0;
    bit          m_rerr = 1'b0;
    bit          m_acc = 1'b0;
    bit          m_rst = 1'b0;

    task automatic model_step();
        bit rdy;
        int unsigned idx;
        m_acc = 1'b0;
        if (!resetn) begin
            mq.delete();
            sweep_left = 0;
            m_plot = 1'b0; m_x = '0; m_y = '0; m_c = '0;
            m_rerr = 1'b0;
            m_rst  = 1'b1;
            return;
        end
        m_rst = 1'b0;
        rdy = (mq.size() != DEPTH);
        if (sweep_left > 0) begin
            idx = NPIX - sweep_left;
            m_x = 8'(idx % W);
            m_y = 7'(idx / W);
            m_c = m_fill;
            m_plot = 1'b1;
            sweep_left--;
        end else if (ENG && clear_start) begin
            sweep_left = NPIX;
            m_fill = clear_color;
            m_plot = 1'b0;
        end else if (mq.size() > 0) begin
            {m_x, m_y, m_c} = mq.pop_front();
            m_plot = 1'b1;
        end else begin
            m_plot = 1'b0;
        end
        if (cpu_plot && rdy) begin
            m_acc = 1'b1;
            if (32'(cpu_x) >= W || 32'(cpu_y) >= H) m_rerr = 1'b1;
            else mq.push_back({cpu_x, cpu_y, cpu_color});
        end
    endtask

    task automatic compare_all();
        check("vga_plot", 32'(vga_plot), 32'(m_plot));
        if (m_plot || m_rst)
            check("pixel", {2'b0, vga_x, vga_y, vga_color}, {2'b0, m_x, m_y, m_c});
        check("pending", 32'(pending), 32'(mq.size()));
        check("cpu_ready", 32'(cpu_ready), 32'(mq.size() != DEPTH));
        check("clear_busy", 32'(clear_busy), 32'(sweep_left > 0));
        check("range_error", 32'(range_error), 32'(m_rerr));
    endtask

    task automatic drive_req();
        if (rq.size() > 0) begin
            cpu_plot = 1'b1;
            {cpu_x, cpu_y, cpu_color} = rq[0];
        end else begin
            cpu_plot = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
        if (m_acc) void'(rq.pop_front());
        drive_req();
    endtask

    function automatic logic [29:0] rand_req();
        logic [7:0] x;
        logic [6:0] y;
        if ($urandom_range(0, 15) == 0) begin
            x = 8'($urandom_range(150, 255));
            y = 7'($urandom_range(110, 127));
        end else begin
            x = 8'($urandom_range(0, W - 1));
            y = 7'($urandom_range(0, H - 1));
        end
        return {x, y, 15'($urandom)};
    endfunction

    function automatic bit model_quiet();
        return (sweep_left == 0) && (rq.size() == 0) && (mq.size() == 0) && !m_plot;
    endfunction

    initial begin
        int cnt;
        bit prev_busy;
        resetn = 1'b0; cpu_plot = 1'b0; cpu_x = '0; cpu_y = '0; cpu_color = '0;
        clear_start = 1'b0; clear_color = '0;
        @(negedge clock);
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // Single plot latency and drain.
        rq.push_back({8'd5, 7'd7, 15'h7FFF});
        drive_req();
        repeat (4) tick();

        // Out-of-range request followed by a valid one.
        rq.push_back({8'd160, 7'd0, 15'h0ABC});
        rq.push_back({8'd10, 7'd10, 15'h1234});
        drive_req();
        repeat (5) tick();

        // Random traffic; without the engine, clear inputs are randomized too.
        for (int i = 0; i < 800; i++) begin
            if (rq.size() == 0 && $urandom_range(0, 2) != 0) rq.push_back(rand_req());
            drive_req();
            clear_start = ENG ? 1'b0 : 1'($urandom);
            clear_color = 15'($urandom);
            tick();
        end
        clear_start = 1'b0;
        for (int i = 0; i < 20 && !model_quiet(); i++) tick();
        check("drain_random", 32'(model_quiet()), 32'd1);

`ifdef FLOW_CLEAR_ENGINE_EN
        // Three plots, clear_start at the first pop opportunity, more plots mid-sweep.
        rq.push_back({8'd1, 7'd2, 15'h0111});
        rq.push_back({8'd3, 7'd4, 15'h0222});
        rq.push_back({8'd159, 7'd119, 15'h0333});
        drive_req();
        tick();
        clear_start = 1'b1;
        clear_color = 15'h001F;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 5; i++) rq.push_back(rand_req());
        drive_req();
        cnt = 0;
        for (int i = 0; i < 25000 && !model_quiet(); i++) begin
            prev_busy = clear_busy;
            clear_color = 15'($urandom);
            tick();
            if (prev_busy && vga_plot) cnt++;
        end
        check("sweep_plots", 32'(cnt), 32'(NPIX));
        check("drain_sweep", 32'(model_quiet()), 32'd1);

        // Second sweep aborted by reset at pixel 1000.
        clear_start = 1'b1;
        clear_color = 15'h7C00;
        tick();
        clear_start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1100 && cnt < 1000; i++) begin
            tick();
            if (vga_plot) cnt++;
        end
        check("abort_reached", 32'(cnt), 32'd1000);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (vga_plot) cnt++;
        end
        check("plot_after_reset", 32'(cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
